// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// RISC-V load/store funct3 codes and default bus widths.
package dmem_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant pick, combinational: round-robin on ties when RR=1,
// otherwise port 0 has fixed priority. A lone requester always wins.
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // last_grant holds the id of the previous winner; the other port wins a tie
    if (req == 2'b11) begin
      gnt = (RR && !last_grant) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between two requesters: latch one
// command, drive the memory for one cycle, then acknowledge the winner.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter bit RR     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [2:0]        funct3_0,
  input  logic [2:0]        funct3_1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        gnt;
  logic              last_grant;
  logic              cmd_id;
  logic              cmd_we;
  logic [2:0]        cmd_funct3;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              take_cmd;

  rr_arb2 #(.RR(RR)) u_arb (
    .req        ({req1, req0}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign take_cmd = (state == IDLE) && (req0 || req1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from state so an async reset drops them at once
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_read  = ~cmd_we;
        mem_write = cmd_we;
      end
      RESP: begin
        ack0 = ~cmd_id;
        ack1 = cmd_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      cmd_id     <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_funct3 <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else if (take_cmd) begin
      last_grant <= gnt[1];
      cmd_id     <= gnt[1];
      cmd_we     <= gnt[1] ? we1      : we0;
      cmd_funct3 <= gnt[1] ? funct3_1 : funct3_0;
      cmd_addr   <= gnt[1] ? addr1    : addr0;
      cmd_wdata  <= gnt[1] ? wdata1   : wdata0;
    end
  end

  // Each port's load result persists until that port's next load completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS && !cmd_we) begin
      if (cmd_id) rdata1 <= mem_rdata;
      else        rdata0 <= mem_rdata;
    end
  end

  assign mem_funct3 = cmd_funct3;
  assign mem_addr   = cmd_addr;
  assign mem_wdata  = cmd_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: two arbiter instances (round-robin and fixed priority),
// each backed by a small behavioural data memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: RR=1
  logic        rst_a, req0_a, req1_a, we0_a, we1_a;
  logic [2:0]  f3_0_a, f3_1_a;
  logic [5:0]  addr0_a, addr1_a;
  logic [31:0] wdata0_a, wdata1_a;
  logic        ack0_a, ack1_a, busy_a, mem_read_a, mem_write_a;
  logic [31:0] rdata0_a, rdata1_a, mem_wdata_a, mem_rdata_a;
  logic [2:0]  mem_funct3_a;
  logic [5:0]  mem_addr_a;
  logic [31:0] mem_a [0:63];

  // Instance B: RR=0
  logic        rst_b, req0_b, req1_b;
  logic        ack0_b, ack1_b, busy_b, mem_read_b, mem_write_b;
  logic [31:0] rdata0_b, rdata1_b, mem_wdata_b, mem_rdata_b;
  logic [2:0]  mem_funct3_b;
  logic [5:0]  mem_addr_b;
  logic [31:0] mem_b [0:63];

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .RR(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .req0(req0_a), .req1(req1_a), .we0(we0_a), .we1(we1_a),
    .funct3_0(f3_0_a), .funct3_1(f3_1_a), .addr0(addr0_a), .addr1(addr1_a),
    .wdata0(wdata0_a), .wdata1(wdata1_a), .ack0(ack0_a), .ack1(ack1_a),
    .rdata0(rdata0_a), .rdata1(rdata1_a), .busy(busy_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_funct3(mem_funct3_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .RR(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .req0(req0_b), .req1(req1_b), .we0(1'b0), .we1(1'b0),
    .funct3_0(F3_W), .funct3_1(F3_W), .addr0(6'd1), .addr1(6'd2),
    .wdata0(32'h0), .wdata1(32'h0), .ack0(ack0_b), .ack1(ack1_b),
    .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_funct3(mem_funct3_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  function automatic logic [31:0] mem_load(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      F3_B:    return {{24{w[7]}}, w[7:0]};
      F3_H:    return {{16{w[15]}}, w[15:0]};
      F3_W:    return w;
      F3_BU:   return {24'h0, w[7:0]};
      F3_HU:   return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mem_store(input logic [31:0] old, input logic [31:0] d,
                                            input logic [2:0] f3);
    case (f3)
      F3_B:    return {old[31:8], d[7:0]};
      F3_H:    return {old[31:16], d[15:0]};
      F3_W:    return d;
      default: return old;
    endcase
  endfunction

  always_comb mem_rdata_a = mem_load(mem_a[mem_addr_a], mem_funct3_a);
  always_comb mem_rdata_b = mem_load(mem_b[mem_addr_b], mem_funct3_b);

  always @(posedge clk) begin
    if (mem_write_a) mem_a[mem_addr_a] <= mem_store(mem_a[mem_addr_a], mem_wdata_a, mem_funct3_a);
    if (mem_write_b) mem_b[mem_addr_b] <= mem_store(mem_b[mem_addr_b], mem_wdata_b, mem_funct3_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack_a(output int n, output logic a0, output logic a1);
    n = 0; a0 = 1'b0; a1 = 1'b0;
    while (n < 10) begin
      tick();
      n++;
      if (ack0_a || ack1_a) begin
        a0 = ack0_a; a1 = ack1_a;
        break;
      end
    end
  endtask

  task automatic wait_ack_b(output int n, output logic a0, output logic a1);
    n = 0; a0 = 1'b0; a1 = 1'b0;
    while (n < 10) begin
      tick();
      n++;
      if (ack0_b || ack1_b) begin
        a0 = ack0_b; a1 = ack1_b;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ack0_a, ack1_a, busy_a, mem_read_a, mem_write_a} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl_a: got %b want 00000", {ack0_a, ack1_a, busy_a, mem_read_a, mem_write_a});
    end
    n_checks++;
    if ({rdata0_a, rdata1_a, mem_addr_a, mem_funct3_a} !== 73'h0) begin
      n_fail++; $display("FAIL reset_regs_a: got %h want 0", {rdata0_a, rdata1_a, mem_addr_a, mem_funct3_a});
    end
    n_checks++;
    if ({ack0_b, ack1_b, busy_b, mem_read_b, mem_write_b} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl_b: got %b want 00000", {ack0_b, ack1_b, busy_b, mem_read_b, mem_write_b});
    end
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
  endtask

  task automatic test_single_load();
    req0_a = 1'b1; we0_a = 1'b0; f3_0_a = F3_W; addr0_a = 6'd0;
    tick();
    n_checks++;
    if ({mem_read_a, mem_write_a, busy_a, ack0_a} !== 4'b1010) begin
      n_fail++; $display("FAIL load_access: got %b want 1010", {mem_read_a, mem_write_a, busy_a, ack0_a});
    end
    n_checks++;
    if (mem_addr_a !== 6'd0 || mem_funct3_a !== F3_W) begin
      n_fail++; $display("FAIL load_addr: got %0d/%b want 0/010", mem_addr_a, mem_funct3_a);
    end
    tick();
    n_checks++;
    if ({ack0_a, ack1_a, mem_read_a} !== 3'b100) begin
      n_fail++; $display("FAIL load_ack: got %b want 100", {ack0_a, ack1_a, mem_read_a});
    end
    n_checks++;
    if (rdata0_a !== 32'd30) begin
      n_fail++; $display("FAIL load_rdata0: got %0d want 30", rdata0_a);
    end
    req0_a = 1'b0;
    tick();
    n_checks++;
    if ({ack0_a, busy_a} !== 2'b00) begin
      n_fail++; $display("FAIL load_idle: got %b want 00", {ack0_a, busy_a});
    end
  endtask

  task automatic test_store_then_load();
    req1_a = 1'b1; we1_a = 1'b1; f3_1_a = F3_W; addr1_a = 6'd10; wdata1_a = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({mem_write_a, mem_read_a} !== 2'b10 || mem_addr_a !== 6'd10 || mem_wdata_a !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_access: got w%b r%b a%0d d%h want w1 r0 a10 dDEADBEEF",
                         mem_write_a, mem_read_a, mem_addr_a, mem_wdata_a);
    end
    tick();
    n_checks++;
    if ({ack0_a, ack1_a, mem_write_a} !== 3'b010) begin
      n_fail++; $display("FAIL store_ack: got %b want 010", {ack0_a, ack1_a, mem_write_a});
    end
    req1_a = 1'b0;
    tick();
    n_checks++;
    if (mem_write_a !== 1'b0 || mem_addr_a !== 6'd10) begin
      n_fail++; $display("FAIL idle_hold: got w%b a%0d want w0 a10", mem_write_a, mem_addr_a);
    end
    req1_a = 1'b1; we1_a = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ack1_a !== 1'b1 || rdata1_a !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_load_rdata1: got ack%b %h want ack1 DEADBEEF", ack1_a, rdata1_a);
    end
    req1_a = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req0_a = 1'b1; we0_a = 1'b1; f3_0_a = F3_W; addr0_a = 6'd5; wdata0_a = 32'h12345678;
    tick();
    n_checks++;
    if (mem_write_a !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got mem_write %b want 1", mem_write_a);
    end
    #2 rst_a = 1'b1;
    #1;
    n_checks++;
    if ({mem_write_a, busy_a, ack0_a} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got %b want 000", {mem_write_a, busy_a, ack0_a});
    end
    n_checks++;
    if (rdata0_a !== 32'h0 || rdata1_a !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_rdata: got %h %h want 0 0", rdata0_a, rdata1_a);
    end
    req0_a = 1'b0;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ack0_a !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_noack: cycle %0d got %b want 0", i, ack0_a);
      end
    end
    n_checks++;
    if (mem_a[5] !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_mem: got %h want 0", mem_a[5]);
    end
  endtask

  task automatic test_early_drop_invalid();
    req0_a = 1'b1; we0_a = 1'b0; f3_0_a = F3_W; addr0_a = 6'd0;
    tick();
    req0_a = 1'b0;
    tick();
    n_checks++;
    if (ack0_a !== 1'b1 || rdata0_a !== 32'd30) begin
      n_fail++; $display("FAIL early_drop: got ack%b %0d want ack1 30", ack0_a, rdata0_a);
    end
    tick();
    req0_a = 1'b1; f3_0_a = 3'b111;
    tick();
    n_checks++;
    if (mem_funct3_a !== 3'b111 || mem_read_a !== 1'b1) begin
      n_fail++; $display("FAIL bad_f3_pass: got %b r%b want 111 r1", mem_funct3_a, mem_read_a);
    end
    tick();
    n_checks++;
    if (ack0_a !== 1'b1 || rdata0_a !== 32'h0) begin
      n_fail++; $display("FAIL bad_f3_load: got ack%b %h want ack1 0", ack0_a, rdata0_a);
    end
    req0_a = 1'b0;
    tick();
  endtask

  task automatic test_contention_rr();
    int n;
    logic a0, a1;
    rst_a = 1'b1;
    req0_a = 1'b1; req1_a = 1'b1; we0_a = 1'b0; we1_a = 1'b0;
    f3_0_a = F3_W; f3_1_a = F3_W; addr0_a = 6'd1; addr1_a = 6'd2;
    tick();
    rst_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack_a(n, a0, a1);
      n_checks++;
      if (n !== ((k == 0) ? 2 : 3)) begin
        n_fail++; $display("FAIL rr_spacing: ack %0d after %0d cycles want %0d", k, n, (k == 0) ? 2 : 3);
      end
      n_checks++;
      if ({a0, a1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_order: ack %0d got %b want %b", k, {a0, a1}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    req0_a = 1'b0; req1_a = 1'b0;
    tick();
  endtask

  task automatic test_contention_fixed();
    int n;
    logic a0, a1;
    rst_b = 1'b1;
    req0_b = 1'b1; req1_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_ack_b(n, a0, a1);
      n_checks++;
      if ({a0, a1} !== 2'b10 || n > 3) begin
        n_fail++; $display("FAIL fixed_prio: ack %0d got %b after %0d cycles want 10", k, {a0, a1}, n);
      end
    end
    req0_b = 1'b0;
    wait_ack_b(n, a0, a1);
    n_checks++;
    if ({a0, a1} !== 2'b01 || n !== 3) begin
      n_fail++; $display("FAIL fixed_drop: got %b after %0d cycles want 01 after 3", {a0, a1}, n);
    end
    n_checks++;
    if (rdata1_b !== 32'h22 || rdata0_b !== 32'h11) begin
      n_fail++; $display("FAIL fixed_rdata: got %h %h want 11 22", rdata0_b, rdata1_b);
    end
    req1_b = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0] = 32'd30;
    mem_b[1] = 32'h11;
    mem_b[2] = 32'h22;
    rst_a = 1'b1; rst_b = 1'b1;
    req0_a = 1'b0; req1_a = 1'b0; we0_a = 1'b0; we1_a = 1'b0;
    f3_0_a = 3'b0; f3_1_a = 3'b0; addr0_a = '0; addr1_a = '0;
    wdata0_a = '0; wdata1_a = '0;
    req0_b = 1'b0; req1_b = 1'b0;
    #1;
    test_reset();
    test_single_load();
    test_store_then_load();
    test_reset_mid();
    test_early_drop_invalid();
    test_contention_rr();
    test_contention_fixed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported data memory of the single-cycle RISC-V core. It shares the memory between port 0 (core load/store path) and port 1 (debug/DMA loader). It latches one requester's command, drives the memory control and address lines for exactly one access cycle, captures read data, and returns a one-cycle acknowledge. Memory-side outputs map directly onto the data memory's MemRead/MemWrite/funct3/addr/data_in/data_out pins.

## Interface
- ADDR_W, 6: word-address width (64-word memory).
- DATA_W, 32: data width.
- RR, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req0 / req1  in  1  access request; held high until matching ack.
- we0 / we1  in  1  1 = store, 0 = load.
- funct3_0 / funct3_1  in  3  RISC-V load/store funct3, passed through unchanged.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  store data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_W  load result; valid in the ack cycle and held until that port's next load completes.
- busy  out  1  high whenever state ≠ IDLE.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_funct3  out  3  to memory funct3.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out (combinational read).

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE:**
  - If req0 or req1 is high, select a winner.
  - Latch the winner's we, funct3, addr and wdata into command registers, and latch the winner id.
  - Go to ACCESS. With no request, stay in IDLE.
- **ACCESS:**
  - mem_read = ~cmd_we and mem_write = cmd_we. Both are decoded from state, so reset clears them immediately.
  - mem_funct3, mem_addr and mem_wdata come from the command registers.
  - On a load, capture mem_rdata into the winner's rdata register at the closing edge.
  - On a store, memory commits at that same closing edge.
  - Go to RESP.
- **RESP:**
  - Assert ack of the winner only. Go to IDLE.
- **Arbitration:**
  - With RR=1, the port not granted last wins a tie. last_grant updates on every latch.
  - With RR=0, port 0 always wins a tie.
  - A single requester always wins.
- **Request held after ack:** a requester that still holds req in the cycle after its ack is treated as a new request.
- **Request dropped early:** dropping req after latch does not cancel the access. The access and ack still complete.
- **funct3:** not checked. Invalid codes pass through; memory ignores them on store and returns 0 on load. The access is still acked.
- **Idle outputs:** outside ACCESS, mem_read = mem_write = 0. mem_addr, mem_funct3 and mem_wdata hold their last latched values.

## Timing
- Reset values:
  - State IDLE.
  - ack0 = ack1 = 0, busy = 0, mem_read = mem_write = 0.
  - Command registers 0; rdata0 = rdata1 = 0.
  - last_grant = 1, so port 0 wins the first tie.
- Latency: a req sampled high in IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2. Load data is valid on rdata in cycle N+2.
- Throughput: one access per 3 cycles, because every RESP returns to IDLE.
- Both ports requesting continuously under RR=1 are serviced alternately: port 0, 1, 0, 1…
- Reset mid-operation:
  - State and ack clear immediately. The in-flight access is abandoned, with no ack.
  - A store whose closing edge coincides with the reset assertion is not guaranteed.
  - Requesters must re-issue after reset.
- Single clock domain; no combinational path from req to ack.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - ADDR_W/DATA_W defaults.
- Sub-module rr_arb2 does the 2-way round-robin/fixed-priority pick.
  - Inputs: req[1:0], last_grant, RR.
  - Outputs: one-hot gnt[1:0].
- The top contains the FSM, command/rdata registers and the memory-side mux.

## Test plan
- **Reset:** rst pulse mid-ACCESS of a port-0 store to addr 5 → mem_write drops in the same cycle, no ack0, busy = 0, rdata = 0.
- **Single load:** port 0 load, funct3 = 010, addr 0, memory word 0 = 30 → ack0 two cycles after req is sampled, rdata0 = 30, one mem_read cycle.
- **Store then load:** port 1 store funct3 = 010, addr 10, wdata 0xDEADBEEF; then port 1 load LW addr 10 → rdata1 = 0xDEADBEEF.
- **Contention, RR=1:** both req high from reset → grants in order 0,1,0,1, and each ack lands 3 cycles apart.
- **Contention, RR=0:** both req held → port 0 is serviced every time until it drops req.
- **Early drop / invalid funct3:** port 0 drops req in ACCESS → ack0 still pulses. A load with funct3 = 111 → acked, rdata0 = 0.
